// File: rtl/am2940.sv
// am2940: 8-bit DMA address generator with control, address and word-count registers/counters
//   clk, rst         : clock and synchronous active-high reset
//   I, datain        : 3-bit instruction and 8-bit operand
//   dataout, addrout : read-back data and address counter
//   done             : transfer-complete flag for the selected mode
//   aci/aco, wci/wco : active-low count enables and carry-outs for cascading
module am2940 (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] I,
   input  logic [7:0] datain,
   output logic [7:0] dataout,
   output logic [7:0] addrout,
   output logic       done,
   input  logic       aci,
   output logic       aco,
   input  logic       wci,
   output logic       wco
);
   logic [2:0] cr;
   logic [7:0] ar, ac, wr, wc;
   logic [1:0] mode;
   logic       down;
   assign mode = cr[1:0];
   assign down = cr[2];
   always_ff @(posedge clk) begin
      if (rst) begin
         cr <= '0;
         ar <= '0;
         ac <= '0;
         wr <= '0;
         wc <= '0;
      end else begin
         case (I)
            3'd0: cr <= datain[2:0];
            3'd4: begin
               ac <= ar;
               wc <= mode == 2'd1 ? 8'h00 : wr;
            end
            3'd5: begin
               ar <= datain;
               ac <= datain;
            end
            3'd6: begin
               wr <= datain;
               wc <= mode == 2'd1 ? 8'h00 : datain;
            end
            3'd7: begin
               if (!aci) ac <= down ? ac - 8'd1 : ac + 8'd1;
               if (!wci) wc <= mode == 2'd0 ? wc - 8'd1 : mode == 2'd2 ? wc : wc + 8'd1;
            end
            default: ;
         endcase
      end
   end
   always_comb begin
      dataout = I == 3'd1 ? {5'b11111, cr} : I == 3'd2 ? wc : I == 3'd3 ? ac : 8'h00;
      addrout = ac;
      done    = mode == 2'd0 ? wc == 8'h01 : mode == 2'd1 ? wc == wr : mode == 2'd2 ? ac == wr : wc == 8'hFF;
      aco     = !(!aci && (down ? ac == 8'h00 : ac == 8'hFF));
      // mode 2 holds the word counter, so it never produces a carry
      wco     = !(!wci && mode != 2'd2 && (mode == 2'd0 ? wc == 8'h00 : wc == 8'hFF));
   end
endmodule

// File: tb/tb_am2940.sv
// tb_am2940: directed self-checking bench for am2940
module tb_am2940;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] I;
   logic [7:0] datain;
   logic [7:0] dataout, addrout;
   logic       done, aci, aco, wci, wco;
   int         passed = 0;
   int         total = 0;
   am2940 dut (
      .clk(clk), .rst(rst), .I(I), .datain(datain), .dataout(dataout), .addrout(addrout),
      .done(done), .aci(aci), .aco(aco), .wci(wci), .wco(wco)
   );
   always #5 clk = ~clk;
   task automatic step(input logic [2:0] i, input logic [7:0] d);
      I = i;
      datain = d;
      @(posedge clk);
      #1;
   endtask
   task automatic rd(input logic [2:0] i);
      I = i;
      #1;
   endtask
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask
   initial begin
      rst = 1'b1; I = 3'd1; datain = 8'h00; aci = 1'b1; wci = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd(3'd0);
      chk("rst_addrout", addrout, 8'h00);
      chk("rst_done", {7'd0, done}, 8'h00);
      chk("rst_dataout", dataout, 8'h00);
      chk("rst_aco", {7'd0, aco}, 8'h01);
      step(3'd0, 8'h06);
      rd(3'd1);
      chk("read_cr_fe", dataout, 8'hFE);
      chk("cr_addrout", addrout, 8'h00);
      step(3'd6, 8'hAA);
      step(3'd5, 8'hAA);
      rd(3'd3);
      chk("read_ac_aa", dataout, 8'hAA);
      chk("addrout_aa", addrout, 8'hAA);
      rd(3'd2);
      chk("read_wc_aa", dataout, 8'hAA);
      step(3'd0, 8'h00);
      aci = 1'b0; wci = 1'b0;
      step(3'd7, 8'h00);
      chk("en_addrout_ab", addrout, 8'hAB);
      rd(3'd2);
      chk("en_wc_a9", dataout, 8'hA9);
      step(3'd4, 8'h00);
      chk("reinit_ac", addrout, 8'hAA);
      rd(3'd2);
      chk("reinit_wc", dataout, 8'hAA);
      step(3'd0, 8'h01);
      step(3'd6, 8'h03);
      rd(3'd2);
      chk("m1_load_wc0", dataout, 8'h00);
      chk("m1_done0", {7'd0, done}, 8'h00);
      step(3'd7, 8'h00);
      step(3'd7, 8'h00);
      rd(3'd2);
      chk("m1_wc2", dataout, 8'h02);
      chk("m1_done_early", {7'd0, done}, 8'h00);
      step(3'd7, 8'h00);
      rd(3'd2);
      chk("m1_wc3", dataout, 8'h03);
      chk("m1_done1", {7'd0, done}, 8'h01);
      step(3'd4, 8'h00);
      rd(3'd2);
      chk("m1_reinit_wc", dataout, 8'h00);
      chk("m1_reinit_done", {7'd0, done}, 8'h00);
      wci = 1'b1;
      step(3'd0, 8'h04);
      step(3'd5, 8'h00);
      chk("dec_aco0", {7'd0, aco}, 8'h00);
      step(3'd7, 8'h00);
      chk("dec_wrap_ff", addrout, 8'hFF);
      chk("dec_aco_ff", {7'd0, aco}, 8'h01);
      aci = 1'b1;
      step(3'd7, 8'h00);
      chk("aci_hold", addrout, 8'hFF);
      step(3'd6, 8'h02);
      chk("m0_done_wc2", {7'd0, done}, 8'h00);
      wci = 1'b0;
      step(3'd7, 8'h00);
      rd(3'd2);
      chk("m0_wc1", dataout, 8'h01);
      chk("m0_done1", {7'd0, done}, 8'h01);
      chk("m0_wco1", {7'd0, wco}, 8'h01);
      step(3'd7, 8'h00);
      rd(3'd2);
      chk("m0_wc0", dataout, 8'h00);
      chk("m0_wco0", {7'd0, wco}, 8'h00);
      chk("m0_done_wc0", {7'd0, done}, 8'h00);
      step(3'd6, 8'h05);
      aci = 1'b0;
      rst = 1'b1;
      step(3'd7, 8'h00);
      rst = 1'b0;
      chk("rst_mid_ac", addrout, 8'h00);
      rd(3'd2);
      chk("rst_mid_wc", dataout, 8'h00);
      rd(3'd1);
      chk("rst_mid_cr", dataout, 8'hF8);
      chk("rst_mid_aco", {7'd0, aco}, 8'h01);
      aci = 1'b1;
      step(3'd0, 8'h03);
      step(3'd6, 8'hFF);
      chk("m3_done", {7'd0, done}, 8'h01);
      chk("m3_wco0", {7'd0, wco}, 8'h00);
      step(3'd7, 8'h00);
      rd(3'd2);
      chk("m3_wrap", dataout, 8'h00);
      chk("m3_done0", {7'd0, done}, 8'h00);
      step(3'd0, 8'h02);
      chk("m2_wco_held", {7'd0, wco}, 8'h01);
      step(3'd7, 8'h00);
      rd(3'd2);
      chk("m2_wc_hold", dataout, 8'h00);
      chk("m2_done", {7'd0, done}, 8'h00);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/am2940.md
# am2940

8-bit DMA address generator modelled on the Am2940. It holds a control register, an address register/counter and a word-count register/counter, and executes one 3-bit instruction per clock. It drives a memory address (`addrout`) and a transfer-complete flag (`done`) to the DMA datapath, and supports cascading through active-low carry-in/carry-out pins.

## Interface
- No parameters; data width is fixed at 8 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `I` input 3: instruction code, sampled every rising edge.
- `datain` input 8: operand for the write/load instructions.
- `dataout` output 8: read-back data.
- `addrout` output 8: always equals the address counter.
- `done` output 1: transfer-complete flag, active-high.
- `aci` input 1: address count enable / carry-in, active-low.
- `aco` output 1: address carry-out, active-low.
- `wci` input 1: word count enable / carry-in, active-low.
- `wco` output 1: word carry-out, active-low.

## Operation
- **State:** CR[2:0] (control register), AR (address register), AC (address counter), WR (word-count register), WC (word counter).
- **CR[1:0] mode:**
  - 0: word-count-equals-zero.
  - 1: word-count compare.
  - 2: address compare.
  - 3: word-counter carry-out.
- **CR[2]:** address direction; 0 increments, 1 decrements.
- **Instructions** (register updates occur at the rising edge while `I` holds the code):
  - 0 WRITE CR: CR <= `datain`[2:0].
  - 1 READ CR: `dataout` = {5'b11111, CR}.
  - 2 READ WC: `dataout` = WC.
  - 3 READ AC: `dataout` = AC.
  - 4 REINIT: AC <= AR. WC <= WR in modes 0, 2 and 3; WC <= 0 in mode 1.
  - 5 LOAD ADDR: AR <= `datain` and AC <= `datain`.
  - 6 LOAD WC: WR <= `datain`. WC <= `datain` in modes 0, 2 and 3; WC <= 0 in mode 1.
  - 7 ENABLE: AC steps by ±1 (per CR[2]) if `aci`=0. If `wci`=0, WC steps as follows:
    - mode 0: −1
    - modes 1 and 3: +1
    - mode 2: holds
- **dataout:** 8'h00 for every instruction other than 1, 2 and 3. Combinational from the current `I` and state.
- **done** (combinational):
  - mode 0: WC == 1.
  - mode 1: WC == WR.
  - mode 2: AC == WR.
  - mode 3: WC == 8'hFF.
- **aco** = 0 iff `aci`=0 and AC is at its terminal value: FF when incrementing, 00 when decrementing.
- **wco** = 0 iff `wci`=0 and WC is at its terminal value: 00 in mode 0, FF in modes 1 and 3. In mode 2, `wco` is held at 1.
- **Arithmetic:** all counters are 8-bit, modulo 256, and wrap silently (FF→00, 00→FF). `done` does not inhibit counting.
- Counters change only under instructions 4–7; the registers AR and WR change only under instructions 5 and 6.
- Changing CR does not alter any counter. The new mode affects `done`, `wco` and the next count step immediately after the edge.

## Timing
- **Reset:**
  - `rst`=1 at an edge clears CR, AR, AC, WR and WC to 0. Reset takes priority over any instruction in that cycle.
  - Post-reset outputs: `addrout`=00, `done`=0, `dataout`=00 (when `I`≠1,2,3). `aco`/`wco` follow the combinational rules from the reset state.
  - Reset asserted mid-count aborts counting at that edge.
- **Write/load latency:** 1 clock. The register is visible on `dataout`/`addrout` after the edge.
- **Read latency:** zero; `dataout` is combinational in the same cycle.
- **ENABLE:** one count step per clock for each consecutive cycle `I`=7 is held.
- **Carry gating:** `aci`/`wci` are sampled at the same edge as the step. Carry outputs are combinational so devices can be cascaded in the same cycle.
- No handshake and no internal FSM beyond the registers.

## Test plan
- Reset, then WRITE CR 8'h06 and READ CR -> `dataout`=8'hFE; `addrout`=00, `done`=0.
- LOAD WC 8'hAA, then LOAD ADDR 8'hAA, then READ AC -> `dataout`=AA and `addrout`=AA; READ WC -> AA.
- WRITE CR 0, then ENABLE for 1 cycle with `aci`=`wci`=0 -> `addrout`=AB, WC=A9. Then REINIT -> AC=AA, WC=AA.
- Mode 1:
  - WRITE CR 1, LOAD WC 8'h03 -> WC=00, `done`=0.
  - ENABLE for 3 cycles -> WC=03 and `done`=1.
  - REINIT -> WC=00, `done`=0.
- Decrement and wrap: CR=4, LOAD ADDR 00 with `aci`=0 -> `aco`=0; ENABLE 1 cycle -> `addrout`=FF. With `aci`=1, ENABLE -> AC holds.
- Mode 0 done and `wco`: LOAD WC 02, then ENABLE -> WC=01 and `done`=1; ENABLE -> WC=00 and `wco`=0. Asserting `rst` during ENABLE -> all counters 00 on the next edge.
